// File: rtl/serial_link_pkg.sv
// serial_link_pkg: definitions shared by both ends of the inter-board serial link.
//   rx_state_e        : receiver FSM state encoding
//   SERIAL_DATA_WIDTH : default data bits per frame
//   SERIAL_OVERSAMPLE : default oversample ticks per bit period
package serial_link_pkg;

  localparam int unsigned SERIAL_DATA_WIDTH = 8;
  localparam int unsigned SERIAL_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eStart = 2'd1,
    eData  = 2'd2,
    eStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/serial_rx_sync.sv
// serial_rx_sync: two-flop synchronizer for asynchronous inputs; resets to all ones
// so an idle-high serial line looks idle straight out of reset.
//   clk_i : system clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
module serial_rx_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: recovers one asynchronous frame (start bit, DATA_WIDTH data
// bits LSB first, one stop bit) and presents it as a parallel word.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   en_i        : oversample tick; FSM, counters and shifter advance only when high
//   rx_i        : asynchronous serial line, idles high
//   data_o      : last correctly framed word, held until the next good frame
//   valid_o     : one-cycle pulse when data_o updates
//   frame_err_o : one-cycle pulse when the stop bit samples low
//   busy_o      : high while a frame is in progress
module serial_frame_receiver #(
  parameter int unsigned DATA_WIDTH = serial_link_pkg::SERIAL_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = serial_link_pkg::SERIAL_OVERSAMPLE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_err_o,
  output logic                  busy_o
);

  import serial_link_pkg::*;

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_WIDTH);

  rx_state_e             r_state,      w_state_nxt;
  logic [SCNT_W-1:0]     r_sample_cnt, w_sample_cnt_nxt;
  logic [BCNT_W-1:0]     r_bit_cnt,    w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift,      w_shift_nxt;
  logic [DATA_WIDTH-1:0] r_data,       w_data_nxt;
  logic                  r_valid,      w_valid_nxt;
  logic                  r_frame_err,  w_frame_err_nxt;
  logic                  r_busy;

  logic                  w_rx_s;
  logic [BCNT_W-1:0]     w_bit_inc;
  logic [DATA_WIDTH-1:0] w_shift_in;

  serial_rx_sync #(.WIDTH(1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (w_rx_s)
  );

  assign w_bit_inc  = r_bit_cnt + BCNT_W'(1);
  // New bit enters at the MSB so the first received bit ends up at the LSB.
  assign w_shift_in = DATA_WIDTH'({w_rx_s, r_shift} >> 1);

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= eIdle;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= (w_state_nxt != eIdle);
    end
  end

  // Next-state and output logic; pulses default low so they last one clock only
  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_data_nxt       = r_data;
    w_valid_nxt      = 1'b0;
    w_frame_err_nxt  = 1'b0;

    if (en_i) begin
      case (r_state)
        eIdle: begin
          if (!w_rx_s) begin
            w_state_nxt      = eStart;
            w_sample_cnt_nxt = '0;
            w_bit_cnt_nxt    = '0;
          end
        end
        eStart: begin
          if (r_sample_cnt == HALF_LAST) begin
            // Re-check mid start bit to reject glitches.
            w_state_nxt      = w_rx_s ? eIdle : eData;
            w_sample_cnt_nxt = '0;
            w_bit_cnt_nxt    = '0;
          end else begin
            w_sample_cnt_nxt = r_sample_cnt + SCNT_W'(1);
          end
        end
        eData: begin
          if (r_sample_cnt == FULL_LAST) begin
            w_shift_nxt      = w_shift_in;
            w_sample_cnt_nxt = '0;
            if (w_bit_inc == BIT_LAST) begin
              w_state_nxt   = eStop;
              w_bit_cnt_nxt = '0;
            end else begin
              w_bit_cnt_nxt = w_bit_inc;
            end
          end else begin
            w_sample_cnt_nxt = r_sample_cnt + SCNT_W'(1);
          end
        end
        eStop: begin
          if (r_sample_cnt == FULL_LAST) begin
            if (w_rx_s) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_frame_err_nxt = 1'b1;
            end
            w_state_nxt      = eIdle;
            w_sample_cnt_nxt = '0;
            w_bit_cnt_nxt    = '0;
          end else begin
            w_sample_cnt_nxt = r_sample_cnt + SCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt      = eIdle;
          w_sample_cnt_nxt = '0;
          w_bit_cnt_nxt    = '0;
        end
      endcase
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed bench for serial_frame_receiver (8 data bits,
// 16x oversampling).
module tb_serial_frame_receiver;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          rx_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          frame_err_o;
  logic          busy_o;

  serial_frame_receiver #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int stretch  = 1;
  int cyc_no   = 0;

  int v_cnt, e_cnt, v_wide, e_wide, both_hi, busy_ok, v_at, t_frame;
  bit prev_v, prev_e, prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clr_stats();
    v_cnt = 0; e_cnt = 0; v_wide = 0; e_wide = 0; both_hi = 0;
    busy_ok = 0; v_at = -1; t_frame = 0;
  endtask

  // One clock: drive en_i pattern, then observe outputs just after the edge.
  task automatic cyc();
    en_i = ((cyc_no % stretch) == 0);
    cyc_no++;
    @(posedge clk_i);
    #1;
    t_frame++;
    if (valid_o) begin
      v_cnt++;
      if (prev_v) v_wide++;
      else begin
        v_at = t_frame;
        if (!busy_o && prev_busy) busy_ok++;
      end
    end
    if (frame_err_o) begin
      e_cnt++;
      if (prev_e) e_wide++;
    end
    if (valid_o && frame_err_o) both_hi++;
    prev_v    = valid_o;
    prev_e    = frame_err_o;
    prev_busy = busy_o;
  endtask

  task automatic hold(input logic b, input int n);
    rx_i = b;
    repeat (n) cyc();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    clr_stats();
    hold(1'b0, OS * stretch);
    for (int i = 0; i < DW; i++) hold(d[i], OS * stretch);
    hold(stop, OS * stretch);
    hold(1'b1, 2 * OS * stretch);
  endtask

  initial begin
    rst_i = 1'b1;
    rx_i  = 1'b1;
    en_i  = 1'b1;
    prev_v = 1'b0; prev_e = 1'b0; prev_busy = 1'b0;
    clr_stats();
    repeat (3) cyc();
    rst_i = 1'b0;

    // Idle line after reset
    hold(1'b1, 200);
    chk("idle_busy",  32'(busy_o), 32'd0);
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_ferr",  32'(frame_err_o), 32'd0);
    chk("idle_data",  32'(data_o), 32'h00);
    chk("idle_pulses", 32'(v_cnt + e_cnt), 32'd0);

    // Good frame A5
    send_frame(8'hA5, 1'b1);
    chk("a5_vcnt",    32'(v_cnt), 32'd1);
    chk("a5_vwide",   32'(v_wide), 32'd0);
    chk("a5_ecnt",    32'(e_cnt), 32'd0);
    chk("a5_data",    32'(data_o), 32'hA5);
    chk("a5_busyfall", 32'(busy_ok), 32'd1);
    // 2 sync + 8 half bit + 9*16 + 1 output register
    chk("a5_latency", 32'(v_at), 32'd155);

    // Bad stop bit on 3C
    send_frame(8'h3C, 1'b0);
    chk("3c_ecnt",  32'(e_cnt), 32'd1);
    chk("3c_ewide", 32'(e_wide), 32'd0);
    chk("3c_vcnt",  32'(v_cnt), 32'd0);
    chk("3c_data",  32'(data_o), 32'hA5);
    chk("3c_busy",  32'(busy_o), 32'd0);

    // Short low glitch is rejected
    clr_stats();
    hold(1'b0, 5);
    hold(1'b1, 40);
    chk("glitch_pulses", 32'(v_cnt + e_cnt), 32'd0);
    chk("glitch_busy",   32'(busy_o), 32'd0);
    chk("glitch_data",   32'(data_o), 32'hA5);

    send_frame(8'hFF, 1'b1);
    chk("ff_vcnt", 32'(v_cnt), 32'd1);
    chk("ff_data", 32'(data_o), 32'hFF);
    chk("ff_both", 32'(both_hi), 32'd0);

    // Slow tick rate: en_i one cycle in four
    stretch = 4;
    cyc_no  = 0;
    send_frame(8'h81, 1'b1);
    stretch = 1;
    chk("81_vcnt",  32'(v_cnt), 32'd1);
    chk("81_vwide", 32'(v_wide), 32'd0);
    chk("81_data",  32'(data_o), 32'h81);
    chk("81_ecnt",  32'(e_cnt), 32'd0);

    // Reset during bit 4 of frame 55
    clr_stats();
    hold(1'b0, OS);
    for (int i = 0; i < 4; i++) hold(((i % 2) == 0) ? 1'b1 : 1'b0, OS);
    hold(1'b1, 8);
    chk("rst_pre_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_busy", 32'(busy_o), 32'd0);
    hold(1'b1, 200);
    chk("rst_pulses", 32'(v_cnt + e_cnt), 32'd0);

    send_frame(8'h12, 1'b1);
    chk("12_vcnt", 32'(v_cnt), 32'd1);
    chk("12_data", 32'(data_o), 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
